// File: rtl/w_debouncer.sv
// Two-flop synchronizer followed by a debounce FSM. A level change on raw_in is
// accepted only after DEBOUNCE_CYCLES consecutive stable samples; aborted attempts are counted.
module w_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                raw_in,
  output logic                w,
  output logic                w_rise,
  output logic                w_fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                s1_q, s2_q;
  logic                w_q, w_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic [GLITCH_W-1:0] glitch_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      state_q  <= STABLE_LOW;
      cnt_q    <= '0;
      w_q      <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      s1_q     <= raw_in;
      s2_q     <= s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_q      <= w_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  always_comb begin
    // Saturate rather than wrap so a long lab run never reads back as "clean".
    glitch_inc = (&glitch_q) ? glitch_q : glitch_q + {{(GLITCH_W-1){1'b0}}, 1'b1};
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_d        = w_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_d   = glitch_q;
    case (state_q)
      STABLE_LOW: begin
        w_d = 1'b0;
        if (s2_q) begin
          state_d = CHECK_HIGH;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      CHECK_HIGH: begin
        if (!s2_q) begin
          state_d  = STABLE_LOW;
          cnt_d    = '0;
          glitch_d = glitch_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
          w_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STABLE_HIGH: begin
        w_d = 1'b1;
        if (!s2_q) begin
          state_d = CHECK_LOW;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      CHECK_LOW: begin
        if (s2_q) begin
          state_d  = STABLE_HIGH;
          cnt_d    = '0;
          glitch_d = glitch_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
          w_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
        w_d     = 1'b0;
      end
    endcase
  end

  assign w          = w_q;
  assign w_rise     = rise_q;
  assign w_fall     = fall_q;
  assign glitch_cnt = glitch_q;
endmodule

// File: tb/tb_w_debouncer.sv
// Randomized and directed bench for w_debouncer against a run-length reference model.
// A second instance with a 2-bit glitch counter covers saturation.
module tb_w_debouncer;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       raw_in = 1'b0;
  logic       w_a, rise_a, fall_a;
  logic [7:0] gc_a;
  logic       w_b, rise_b, fall_b;
  logic [1:0] gc_b;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: synchronizer delay line plus count of consecutive
  // samples disagreeing with the accepted level
  bit m_s1, m_s2, m_w, m_rise, m_fall;
  int m_run, m_glitch;

  w_debouncer #(.DEBOUNCE_CYCLES(DC), .GLITCH_W(8)) dut_a (
    .clk(clk), .reset(reset), .raw_in(raw_in),
    .w(w_a), .w_rise(rise_a), .w_fall(fall_a), .glitch_cnt(gc_a));

  w_debouncer #(.DEBOUNCE_CYCLES(DC), .GLITCH_W(2)) dut_b (
    .clk(clk), .reset(reset), .raw_in(raw_in),
    .w(w_b), .w_rise(rise_b), .w_fall(fall_b), .glitch_cnt(gc_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_edge(input bit r, input bit rst);
    bit seen;
    m_rise = 0;
    m_fall = 0;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_w = 0; m_run = 0; m_glitch = 0;
      return;
    end
    seen = m_s2;
    m_s2 = m_s1;
    m_s1 = r;
    if (seen == m_w) begin
      if (m_run > 0) m_glitch++;
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == DC) begin
        m_w = seen;
        m_rise = seen;
        m_fall = !seen;
        m_run = 0;
      end
    end
  endtask

  // one clock: drive on negedge, model the posedge, compare 1 time unit later
  task automatic step(input bit r, input bit rst);
    @(negedge clk);
    raw_in = r;
    reset = rst;
    @(posedge clk);
    model_edge(r, rst);
    #1;
    chk("w_a", int'(w_a), int'(m_w));
    chk("rise_a", int'(rise_a), int'(m_rise));
    chk("fall_a", int'(fall_a), int'(m_fall));
    chk("glitch_a", int'(gc_a), sat(m_glitch, 255));
    chk("w_b", int'(w_b), int'(m_w));
    chk("glitch_b", int'(gc_b), sat(m_glitch, 3));
    chk("no_both_strobes", int'(rise_a & fall_a), 0);
  endtask

  task automatic do_reset(input bit r);
    step(r, 1'b1);
    step(r, 1'b1);
  endtask

  initial begin
    int rise_at, fall_at, rises, falls;

    // reset state with raw_in high
    do_reset(1'b1);
    chk("rst_w", int'(w_a), 0);
    chk("rst_glitch", int'(gc_a), 0);
    chk("rst_strobes", int'(rise_a | fall_a), 0);

    // clean press: w_rise at edge 5 only
    do_reset(1'b0);
    rise_at = -1; rises = 0; falls = 0;
    for (int e = 0; e < 10; e++) begin
      step(1'b1, 1'b0);
      if (rise_a) begin rise_at = e; rises++; end
      if (fall_a) falls++;
    end
    chk("press_rise_edge", rise_at, DC + 1);
    chk("press_rise_count", rises, 1);
    chk("press_fall_count", falls, 0);
    chk("press_w", int'(w_a), 1);
    chk("press_glitch", int'(gc_a), 0);

    // release from w=1
    fall_at = -1; rises = 0;
    for (int e = 0; e < 10; e++) begin
      step(1'b0, 1'b0);
      if (fall_a) fall_at = e;
      if (rise_a) rises++;
    end
    chk("release_fall_edge", fall_at, DC + 1);
    chk("release_rise_count", rises, 0);
    chk("release_w", int'(w_a), 0);

    // glitch of 2 clocks
    do_reset(1'b0);
    rises = 0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int e = 0; e < 6; e++) begin
      step(1'b0, 1'b0);
      if (rise_a) rises++;
    end
    chk("glitch_w", int'(w_a), 0);
    chk("glitch_rises", rises, 0);
    chk("glitch_cnt1", int'(gc_a), 1);

    // bounce train 1,0,1,1,0 then hold 1
    do_reset(1'b0);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    rise_at = -1; rises = 0;
    for (int e = 0; e < 10; e++) begin
      step(1'b1, 1'b0);
      if (rise_a) begin rise_at = e; rises++; end
    end
    chk("bounce_glitch", int'(gc_a), 2);
    chk("bounce_rise_edge", rise_at, DC + 1);
    chk("bounce_rise_count", rises, 1);

    // reset during CHECK_HIGH discards the pending change
    do_reset(1'b0);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("midrst_w", int'(w_a), 0);
    chk("midrst_glitch", int'(gc_a), 0);
    rise_at = -1;
    for (int e = 0; e < 10; e++) begin
      step(1'b1, 1'b0);
      if (rise_a && rise_at < 0) rise_at = e;
    end
    chk("midrst_rise_edge", rise_at, DC + 1);

    // saturation of the 2-bit counter after 5 glitches
    do_reset(1'b0);
    for (int g = 0; g < 5; g++) begin
      step(1'b1, 1'b0); step(1'b1, 1'b0);
      for (int e = 0; e < 4; e++) step(1'b0, 1'b0);
    end
    chk("sat_glitch_b", int'(gc_b), 3);
    chk("sat_glitch_a", int'(gc_a), 5);

    // random runs with occasional reset
    do_reset(1'b0);
    for (int r = 0; r < 200; r++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 24) == 0) step(lvl, 1'b1);
      for (int k = 0; k < len; k++) step(lvl, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/w_debouncer.md
# w_debouncer

Input conditioning stage that feeds the sequence-detector FSM's `w` input. Passes a raw, asynchronous, bouncy switch/button level through a two-flop synchronizer, then a debounce state machine that accepts a level change only after it has held steadily for `DEBOUNCE_CYCLES` consecutive clocks. Drives a clean `w` level plus one-cycle edge strobes, and keeps a saturating count of rejected glitches for lab diagnostics.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a change; legal range 2..65535.
- `GLITCH_W`, default 8: width of the glitch counter.
- `clk` in 1: sole clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `raw_in` in 1: asynchronous raw switch level.
- `w` out 1: debounced level, registered.
- `w_rise` out 1: one-cycle pulse when `w` goes 0→1.
- `w_fall` out 1: one-cycle pulse when `w` goes 1→0.
- `glitch_cnt` out GLITCH_W: number of aborted transitions, saturating.

## Operation
- Synchronizer: `s1 <= raw_in; s2 <= s1`; FSM sees only `s2`.
- Counter `cnt`, width clog2(DEBOUNCE_CYCLES+1), counts consecutive samples that differ from `w`.
- States:
  - STABLE_LOW (w=0): `s2`=1 → CHECK_HIGH, cnt=1; else stay, cnt=0.
  - CHECK_HIGH (w=0): `s2`=0 → STABLE_LOW, cnt=0, glitch_cnt+1. `s2`=1 and cnt==DEBOUNCE_CYCLES-1 → STABLE_HIGH, w<=1, w_rise<=1, cnt=0. `s2`=1 otherwise → cnt+1.
  - STABLE_HIGH (w=1): mirror of STABLE_LOW, with `s2`=0 → CHECK_LOW.
  - CHECK_LOW (w=1): mirror of CHECK_HIGH; acceptance sets w<=0, w_fall<=1; abort returns to STABLE_HIGH and increments glitch_cnt.
- `w_rise`/`w_fall` are high for exactly one cycle and are never asserted together.
- glitch_cnt saturates at 2^GLITCH_W-1 and never wraps; only reset clears it.
- Unused state encodings go to STABLE_LOW on the next edge, with w=0 and no strobes.

## Timing
- Reset, sampled on a rising edge: s1=s2=0, state STABLE_LOW, cnt=0, w=0, w_rise=0, w_fall=0, glitch_cnt=0. This holds regardless of `raw_in`.
- Reset asserted during CHECK_*: the pending change is discarded and glitch_cnt is not incremented.
- Latency: let edge 0 be the first edge that samples `raw_in` at its new level, with the level held thereafter. `s2` is valid after edge 1. `w` and the strobe update at edge DEBOUNCE_CYCLES+1. With the default of 4, that is edge 5.
- `raw_in` at its new level during reset: edge 0 is the first post-reset edge. If `raw_in` is high, w rises at edge DEBOUNCE_CYCLES+1 after reset release.
- Minimum accepted pulse width on `raw_in` is DEBOUNCE_CYCLES clocks. Any shorter stable run counts as a glitch.
- Abort and restart in the same cycle are not possible. An abort returns to STABLE_*, and the opposite CHECK can start one edge later at the earliest.

## Test plan
- Clean press, DEBOUNCE_CYCLES=4: reset, then raw_in 0→1 held. Required: w=1 and w_rise=1 at edge 5 only; w_fall=0 throughout; glitch_cnt=0.
- Glitch rejection: raw_in high for 2 clocks, then low. Required: w stays 0, no strobes, glitch_cnt=1 about 4 edges later.
- Bounce train: raw_in toggles 1,0,1,1,0 at one clock per step, then holds 1. Required: glitch_cnt=2; w rises exactly 5 edges after the final hold begins; a single w_rise pulse.
- Release: from w=1, raw_in→0 held. Required: w=0 and w_fall=1 at edge 5; w_rise=0.
- Reset mid-operation: reset pulsed at edge 3 of a press. Required: w=0 and glitch_cnt=0 after reset. With raw_in still high, w rises 5 edges after reset release.
- Saturation, GLITCH_W=2: 5 glitches. Required: glitch_cnt ends at 3, with no wrap to 0.
